// File: rtl/set_sequencer.sv
// set_sequencer: sequences the shared ALU subtract path to produce an unsigned
// set-compare result (SLT/SLE/SGT/SGE/SEQ/SNE) over a valid/ready handshake.
module set_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             alu_sub,
    output logic             alu_en,
    input  logic             alu_cout,
    input  logic             alu_zero,
    output logic [WIDTH-1:0] result,
    output logic             valid,
    input  logic             ack,
    output logic             err,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, DRIVE, EVAL, HOLD} state_t;

    state_t           state, nxt;
    logic [WIDTH-1:0] opa, opb;
    logic [2:0]       opr;
    logic             cf, zf, lt, le, ill, res_bit, accept;

    assign accept = (state == IDLE) && start;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            opa    <= '0;
            opb    <= '0;
            opr    <= '0;
            cf     <= 1'b0;
            zf     <= 1'b0;
            result <= '0;
            err    <= 1'b0;
        end else begin
            state <= nxt;
            if (accept) begin
                // SGT/SGE reuse the less-than logic by swapping operands
                opa    <= (op[2:1] == 2'b01) ? b : a;
                opb    <= (op[2:1] == 2'b01) ? a : b;
                opr    <= op;
                result <= '0;
                err    <= 1'b0;
            end
            if (state == DRIVE) begin
                cf <= alu_cout;
                zf <= alu_zero;
            end
            if (state == EVAL) begin
                result <= WIDTH'(res_bit);
                err    <= ill;
            end
        end
    end

    always_comb begin
        nxt     = state;
        lt      = !cf && !zf;
        le      = !cf || zf;
        ill     = opr[2] && opr[1];
        res_bit = ill ? 1'b0 : opr[2] ? (opr[0] ? !zf : zf) : (opr[0] ? le : lt);
        case (state)
            IDLE:  nxt = start ? DRIVE : IDLE;
            DRIVE: nxt = EVAL;
            EVAL:  nxt = HOLD;
            HOLD:  nxt = ack ? IDLE : HOLD;
            default: nxt = IDLE;
        endcase
    end

    assign busy    = state != IDLE;
    assign valid   = state == HOLD;
    assign alu_en  = state == DRIVE;
    assign alu_sub = alu_en;
    assign alu_a   = alu_en ? opa : '0;
    assign alu_b   = alu_en ? opb : '0;
endmodule

// File: doc/set_sequencer.md
# set_sequencer

Multi-cycle controller that sequences the shared ALU subtract path to produce a 32-bit set-instruction result (0 or 1) for SLT, SLE, SGT, SGE, SEQ and SNE. It sits between the decode stage and the ALU and owns the ALU operand muxes while a compare is in flight. It uses a valid/ready handshake on both sides, so the decoder can issue a compare and the writeback stage can collect the result independently.

## Interface
- WIDTH, 32, operand and result width
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start  in  1  request to begin a compare; accepted only when busy=0
- op  in  3  000 SLT, 001 SLE, 010 SGT, 011 SGE, 100 SEQ, 101 SNE, 110/111 illegal
- a, b  in  WIDTH  operands, sampled on the accept cycle
- alu_a, alu_b  out  WIDTH  operands driven to the shared ALU
- alu_sub  out  1  ALU subtract select (A + ~B + 1)
- alu_en  out  1  sequencer owns the ALU this cycle
- alu_cout, alu_zero  in  1  ALU carry-out and zero flags (combinational from alu_a/alu_b)
- result  out  WIDTH  32'h00000001 or 32'h00000000
- valid  out  1  result available
- ack  in  1  consumer takes result
- err  out  1  result is for an illegal op
- busy  out  1  high in every state except IDLE

## Operation
- Compare is unsigned. Cout=1 means no borrow (A ≥ B). Zero=1 means A == B.
- States: IDLE, DRIVE, EVAL, HOLD.
- IDLE: busy=0. On start=1, latch a, b, op and go to DRIVE. For SGT/SGE, latch the operands swapped (alu_a←b, alu_b←a).
- DRIVE: alu_en=1, alu_sub=1, alu_a/alu_b = latched operands. At the clock edge, capture alu_cout and alu_zero into flag registers, then go to EVAL.
- EVAL: compute the result from the captured flags, register it, then go to HOLD:
  - SLT/SGT: 1 if !Cout && !Zero
  - SLE/SGE: 1 if !Cout || Zero
  - SEQ: 1 if Zero
  - SNE: 1 if !Zero
  - Illegal op: result 0, err=1
- HOLD: valid=1, result and err stable. ack=1 returns to IDLE at the next edge. Without ack, HOLD persists indefinitely.
- start while busy=1 is ignored and not queued.
- Illegal op still walks DRIVE/EVAL, so latency is the same for every op.
- alu_a, alu_b and alu_sub are 0 whenever alu_en=0.

## Timing
- Reset values: state IDLE; busy, valid, err, alu_en, alu_sub 0; result, alu_a, alu_b 0; latched operands and flags 0.
- Accept edge = edge 0:
  - DRIVE during cycle 1
  - EVAL during cycle 2
  - valid=1 from cycle 3
  - Latency is 3 cycles from accept to valid.
- With ack asserted in the first HOLD cycle, busy falls in cycle 4 and a new start is accepted at the end of cycle 4. Maximum throughput is one compare per 4 cycles.
- ack outside HOLD is ignored.
- In HOLD, valid and ack together complete the handshake. result stays valid until the edge that consumes it.
- Reset mid-operation, in any state, takes effect at the next edge:
  - state returns to IDLE and all outputs clear
  - the in-flight compare is discarded, with no valid pulse
- reset and start in the same cycle: reset wins, and the request is not accepted.
- Flags are sampled only at the DRIVE→EVAL edge. ALU flag changes in any other cycle have no effect.

## Test plan
- Basic SLT: a=5, b=9, op=000, ALU model returns Cout=0, Zero=0 → valid in cycle 3, result=1, err=0; ack → busy=0 in cycle 4.
- SLE/SEQ equality: a=b=32'h0000_0040. SLE → 1, SEQ → 1, SNE → 0, SLT → 0.
- Swap path: op=010 (SGT), a=32'hFFFF_FFFF, b=1 → alu_a=1, alu_b=32'hFFFF_FFFF during DRIVE, result=1; same operands with op=011 (SGE) → 1.
- Backpressure and start while busy:
  - hold ack=0 for 10 cycles in HOLD → result and valid stable, busy=1
  - pulse start mid-hold → ignored
  - ack → IDLE, then the next start completes normally
- Illegal op 110: → valid after 3 cycles with result=0, err=1; err clears on the next accepted legal op.
- Reset mid-operation: assert reset during EVAL → next cycle all outputs 0, state IDLE, no valid pulse. reset coincident with start → no accept.
